mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction caches and data caches of CPUS cores.
- Sits between the caches' memory-side interfaces and the RAM model/controller.
- Registers one grant at a time and holds it for a full block transfer of BURST_WORDS words.
- Returns the per-requester wait/load handshake that the caches already expect.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter_rr_picker.sv | 26 ++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM status encoding, arbiter FSM states
// and a helper sizing the requester index.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int WORD_W = 32;

    // Width of a requester index over 2*cpus requesters, never below one bit.
    function automatic int arb_req_w(input int cpus);
        return (2 * cpus > 1) ? $clog2(2 * cpus) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the memory arbiter.
// slave: the arbiter's view; master: the caches and RAM model driving it.
interface mem_arbiter_if #(
    parameter int CPUS = 2
) ();
    import mem_arbiter_pkg::*;

    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*WORD_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        iREN;
    logic [CPUS*WORD_W-1:0] iaddr;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] dload;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*WORD_W-1:0] iload;

    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    ramstate_t              ramstate;

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around; vld is low when no request is asserted.
module mem_arbiter_rr_picker #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] win,
    output logic         vld
);

    always_comb begin
        win = '0;
        vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!vld && req[j]) begin
                vld = 1'b1;
                win = W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among CPUS dcaches (0..CPUS-1) and icaches (CPUS..2*CPUS-1),
// holding each grant for a BURST_WORDS block. `define ARB_DPRIO_EN to favour dcaches.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CPUS        = 2,
    parameter int BURST_WORDS = 2
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);

    localparam int N  = 2 * CPUS;
    localparam int RW = arb_req_w(CPUS);
    localparam int CW = $clog2(BURST_WORDS) + 1;

    arb_state_t          state, state_n;
    logic [RW-1:0]       gnt, gnt_n;
    logic [RW-1:0]       rr, rr_n;
    logic [CW-1:0]       cnt, cnt_n;

    logic [RW-1:0]       win;
    logic                win_vld;

    logic                g_act, g_ren, g_wen;
    logic [WORD_W-1:0]   g_addr, g_store;
    logic                done;

    function automatic logic [RW-1:0] rr_next(input logic [RW-1:0] g);
        return (g == RW'(N - 1)) ? '0 : g + 1'b1;
    endfunction

`ifdef ARB_DPRIO_EN
    localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;

    logic [GW-1:0] d_ptr, i_ptr, d_win, i_win;
    logic          d_vld, i_vld;

    // Each group resumes from rr when rr points into it, otherwise from its first member.
    assign d_ptr = (rr < RW'(CPUS))  ? GW'(rr) : '0;
    assign i_ptr = (rr >= RW'(CPUS)) ? GW'(rr - RW'(CPUS)) : '0;

    mem_arbiter_rr_picker #(.N(CPUS)) u_pick_d (
        .req (bus.dREN | bus.dWEN),
        .ptr (d_ptr),
        .win (d_win),
        .vld (d_vld)
    );

    mem_arbiter_rr_picker #(.N(CPUS)) u_pick_i (
        .req (bus.iREN),
        .ptr (i_ptr),
        .win (i_win),
        .vld (i_vld)
    );

    assign win     = d_vld ? RW'(d_win) : RW'(i_win) + RW'(CPUS);
    assign win_vld = d_vld | i_vld;
`else
    mem_arbiter_rr_picker #(.N(N)) u_pick (
        .req ({bus.iREN, bus.dREN | bus.dWEN}),
        .ptr (rr),
        .win (win),
        .vld (win_vld)
    );
`endif

    // Mux the granted requester's controls onto a common set of signals.
    always_comb begin
        g_act   = 1'b0;
        g_ren   = 1'b0;
        g_wen   = 1'b0;
        g_addr  = '0;
        g_store = '0;
        for (int k = 0; k < CPUS; k++) begin
            if (gnt == RW'(k)) begin
                g_act   = bus.dREN[k] | bus.dWEN[k];
                g_wen   = bus.dWEN[k];
                g_ren   = bus.dREN[k] & ~bus.dWEN[k];
                g_addr  = bus.daddr[k*WORD_W +: WORD_W];
                g_store = bus.dstore[k*WORD_W +: WORD_W];
            end
            if (gnt == RW'(k + CPUS)) begin
                g_act  = bus.iREN[k];
                g_ren  = bus.iREN[k];
                g_addr = bus.iaddr[k*WORD_W +: WORD_W];
            end
        end
    end

    assign done = (state == GRANT) && g_act && (bus.ramstate == ACCESS);

    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        rr_n         = rr;
        cnt_n        = cnt;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    gnt_n   = win;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                bus.ramaddr  = g_addr;
                bus.ramstore = g_store;
                if (!g_act) begin
                    // Requester abandoned the block: release without a RAM command.
                    state_n = IDLE;
                    rr_n    = rr_next(gnt);
                end else begin
                    bus.ramREN = g_ren;
                    bus.ramWEN = g_wen;
                    if (done) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt == CW'(BURST_WORDS - 1)) begin
                            state_n = IDLE;
                            rr_n    = rr_next(gnt);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.dwait = '1;
        bus.iwait = '1;
        bus.dload = '0;
        bus.iload = '0;
        for (int k = 0; k < CPUS; k++) begin
            if (done && gnt == RW'(k)) begin
                bus.dwait[k]                   = 1'b0;
                bus.dload[k*WORD_W +: WORD_W]  = bus.ramload;
            end
            if (done && gnt == RW'(k + CPUS)) begin
                bus.iwait[k]                   = 1'b0;
                bus.iload[k*WORD_W +: WORD_W]  = bus.ramload;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt   <= '0;
            rr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            rr    <= rr_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (CPUS=2, BURST_WORDS=2): expected completions
// are queued when ACCESS is driven and popped when a wait drops.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        int          who;
        logic [31:0] data;
    } exp_t;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    mem_arbiter_if #(.CPUS(2)) bif ();

    mem_arbiter #(.CPUS(2), .BURST_WORDS(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bif)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    // One ACCESS cycle returning d; requester 'who' must complete with d.
    task automatic access(input int who, input logic [31:0] d);
        exp_t e;
        e.who  = who;
        e.data = d;
        sb_q.push_back(e);
        bif.ramstate = ACCESS;
        bif.ramload  = d;
        @(posedge CLK);
        #2;
        bif.ramstate = FREE;
        bif.ramload  = '0;
    endtask

    // r: {i1,i0,d1,d0}; wmask marks dcaches that write instead of read.
    task automatic apply_req(input logic [3:0] r, input logic [1:0] wmask);
        bif.dREN = r[1:0] & ~wmask;
        bif.dWEN = r[1:0] & wmask;
        bif.iREN = r[3:2];
    endtask

    function automatic logic [31:0] addr_of(input int who);
        case (who)
            0:       return 32'h40;
            1:       return 32'h80;
            2:       return 32'h100;
            default: return 32'h140;
        endcase
    endfunction

    always @(negedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            logic        w;
            logic [31:0] ld;
            w  = (k < 2) ? bif.dwait[k] : bif.iwait[k-2];
            ld = (k < 2) ? bif.dload[k*32 +: 32] : bif.iload[(k-2)*32 +: 32];
            if (!w) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected_done", 64'(k), 64'hFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("sb_who", 64'(k), 64'(e.who));
                    check_val("sb_data", ld, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rot[5];
        logic [31:0] wd;
        n_checks     = 0;
        n_errors     = 0;
        CLK          = 1'b0;
        nRST         = 1'b0;
        bif.dREN     = '0;
        bif.dWEN     = '0;
        bif.iREN     = 2'b01;
        bif.daddr    = {32'h80, 32'h40};
        bif.dstore   = {32'hD1D1_0001, 32'hD0D0_0000};
        bif.iaddr    = {32'h140, 32'h100};
        bif.ramstate = FREE;
        bif.ramload  = '0;

        // Reset held with icache0 requesting
        repeat (2) cyc();
        check_val("rst_dwait", bif.dwait, 2'b11);
        check_val("rst_iwait", bif.iwait, 2'b11);
        check_val("rst_ramREN", bif.ramREN, 0);
        check_val("rst_ramWEN", bif.ramWEN, 0);
        check_val("rst_ramaddr", bif.ramaddr, 0);
        check_val("rst_ramstore", bif.ramstore, 0);
        check_val("rst_dload", bif.dload, 0);
        check_val("rst_iload", bif.iload, 0);
        nRST = 1'b1;
        #1;
        check_val("rel_idle_ren", bif.ramREN, 0);
        cyc();
        #1;
        check_val("rel_gnt_ren", bif.ramREN, 1);
        check_val("rel_gnt_addr", bif.ramaddr, 32'h100);
        access(2, 32'h1111_0001);
        access(2, 32'h1111_0002);
        apply_req(4'b0000, 2'b00);

        // Single dcache read burst
        cyc();
        apply_req(4'b0001, 2'b00);
        cyc();
        #1;
        check_val("rd_ren", bif.ramREN, 1);
        check_val("rd_wen", bif.ramWEN, 0);
        check_val("rd_addr", bif.ramaddr, 32'h40);
        access(0, 32'hAAAA);
        access(0, 32'hBBBB);
        apply_req(4'b0000, 2'b00);
        #1;
        check_val("rd_done_ren", bif.ramREN, 0);
        check_val("rd_done_state", dut.state, IDLE);
        check_val("rd_done_rr", dut.rr, 1);

        // Contention: icache0 read vs dcache1 write, dcache1 first
        cyc();
        apply_req(4'b0110, 2'b10);
        cyc();
        #1;
        check_val("ct_wen", bif.ramWEN, 1);
        check_val("ct_ren", bif.ramREN, 0);
        check_val("ct_addr", bif.ramaddr, 32'h80);
        check_val("ct_store", bif.ramstore, 32'hD1D1_0001);
        access(1, 32'hC0DE_0001);
        access(1, 32'hC0DE_0002);
        apply_req(4'b0100, 2'b00);
        cyc();
        #1;
        check_val("ct2_ren", bif.ramREN, 1);
        check_val("ct2_addr", bif.ramaddr, 32'h100);
        access(2, 32'hC0DE_0003);
        access(2, 32'hC0DE_0004);
        apply_req(4'b0000, 2'b00);

        // Early release by icache0 after one word
        cyc();
        apply_req(4'b0100, 2'b00);
        cyc();
        #1;
        check_val("er_ren", bif.ramREN, 1);
        access(2, 32'hE000_0001);
        apply_req(4'b0000, 2'b00);
        #1;
        check_val("er_drop_ren", bif.ramREN, 0);
        cyc();
        check_val("er_state", dut.state, IDLE);
        check_val("er_rr", dut.rr, 3);

        // ERROR holds the grant without completing words
        apply_req(4'b0010, 2'b00);
        cyc();
        #1;
        bif.ramstate = ERROR;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_val("err_ren", bif.ramREN, 1);
            check_val("err_addr", bif.ramaddr, 32'h80);
        end
        access(1, 32'hEEEE_0001);
        access(1, 32'hEEEE_0002);
        apply_req(4'b0000, 2'b00);
        #1;
        check_val("err_rr", dut.rr, 2);

        // Asynchronous reset in the middle of a burst
        cyc();
        apply_req(4'b0001, 2'b00);
        cyc();
        #1;
        access(0, 32'h5555_0001);
        #1;
        check_val("mr_pre_ren", bif.ramREN, 1);
        nRST = 1'b0;
        #1;
        check_val("mr_dwait", bif.dwait, 2'b11);
        check_val("mr_iwait", bif.iwait, 2'b11);
        check_val("mr_ren", bif.ramREN, 0);
        check_val("mr_addr", bif.ramaddr, 0);
        check_val("mr_state", dut.state, IDLE);
        check_val("mr_rr", dut.rr, 0);
        apply_req(4'b0000, 2'b00);
        cyc();
        nRST = 1'b1;
        cyc();

        // Round-robin fairness with every requester held high
`ifdef ARB_DPRIO_EN
        rot = '{0, 1, 0, 1, 0};
`else
        rot = '{0, 1, 2, 3, 0};
`endif
        apply_req(4'b1111, 2'b00);
        for (int b = 0; b < 5; b++) begin
            cyc();
            #1;
            check_val("rr_ren", bif.ramREN, 1);
            check_val("rr_addr", bif.ramaddr, addr_of(rot[b]));
            wd = 32'h7000_0000 + 32'(b * 2);
            access(rot[b], wd);
            access(rot[b], wd + 32'd1);
        end
        apply_req(4'b0000, 2'b00);

        cyc();
        cyc();
        check_val("sb_drained", 64'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
